// File: rtl/conv_pe_tile_scheduler.sv
// rtl/conv_pe_tile_scheduler.sv - tile sequencer feeding the 4x4 systolic conv PE array
module conv_pe_tile_scheduler #(
    parameter int IMG_AW = 10,
    parameter int W_AW   = 10,
    parameter int RES_AW = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_pix_grp,
    input  logic [CNT_W-1:0]  i_num_ker_grp,
    input  logic [IMG_AW-1:0] i_img_base,
    input  logic [W_AW-1:0]   i_w_base,
    input  logic [RES_AW-1:0] i_res_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_img_rd_en,
    output logic [IMG_AW-1:0] o_img_rd_addr,
    input  logic [143:0]      i_img_rd_data,
    output logic              o_w_rd_en,
    output logic [W_AW-1:0]   o_w_rd_addr,
    input  logic [143:0]      i_w_rd_data,
    output logic              o_arr_rst,
    output logic              o_arr_data_in_en,
    output logic [575:0]      o_arr_img,
    output logic [575:0]      o_arr_w,
    input  logic [63:0]       i_arr_data,
    input  logic              i_arr_data_en,
    output logic              o_res_we,
    output logic [RES_AW-1:0] o_res_addr,
    output logic [63:0]       o_res_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LAUNCH, S_DRAIN, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        f_cnt;
    logic [CNT_W-1:0]  p_cnt, k_cnt, num_p, num_k;
    logic [IMG_AW-1:0] img_base;
    logic [W_AW-1:0]   w_base;
    logic [RES_AW-1:0] res_base, t_cnt;
    logic [143:0]      img_stage [4];
    logic [143:0]      w_stage   [4];
    logic              array_free;
    logic [1:0]        beat_cnt;
    logic              res_we, res_last;
    logic [RES_AW-1:0] res_addr;
    logic [63:0]       res_data;

    logic beat_take, fourth_beat, free_now, last_pix, last_tile;

    assign beat_take   = i_arr_data_en & ~array_free;
    assign fourth_beat = beat_take & (beat_cnt == 2'd3);
    // Looking ahead at the 4th beat lets the next launch land exactly 17 cycles after the last.
    assign free_now    = array_free | fourth_beat;
    assign last_pix    = (p_cnt + CNT_W'(1)) == num_p;
    assign last_tile   = last_pix && ((k_cnt + CNT_W'(1)) == num_k);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start)
                    state_nxt = (i_num_pix_grp == '0 || i_num_ker_grp == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (f_cnt == 3'd4)
                    state_nxt = free_now ? S_LAUNCH : S_WAIT;
            end
            S_WAIT: begin
                if (free_now)
                    state_nxt = S_LAUNCH;
            end
            S_LAUNCH: state_nxt = last_tile ? S_DRAIN : S_FETCH;
            S_DRAIN: begin
                if (res_last)
                    state_nxt = S_DONE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            f_cnt      <= '0;
            p_cnt      <= '0;
            k_cnt      <= '0;
            num_p      <= '0;
            num_k      <= '0;
            img_base   <= '0;
            w_base     <= '0;
            res_base   <= '0;
            t_cnt      <= '0;
            array_free <= 1'b1;
            beat_cnt   <= '0;
            res_we     <= 1'b0;
            res_last   <= 1'b0;
            res_addr   <= '0;
            res_data   <= '0;
            for (int i = 0; i < 4; i++) begin
                img_stage[i] <= '0;
                w_stage[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && i_start) begin
                num_p    <= i_num_pix_grp;
                num_k    <= i_num_ker_grp;
                img_base <= i_img_base;
                w_base   <= i_w_base;
                res_base <= i_res_base;
                p_cnt    <= '0;
                k_cnt    <= '0;
                t_cnt    <= '0;
                f_cnt    <= '0;
            end
            if (state == S_FETCH) begin
                f_cnt <= (f_cnt == 3'd4) ? 3'd0 : f_cnt + 3'd1;
                if (f_cnt != 3'd0) begin
                    img_stage[2'(f_cnt - 3'd1)] <= i_img_rd_data;
                    w_stage[2'(f_cnt - 3'd1)]   <= i_w_rd_data;
                end
            end
            if (state == S_LAUNCH) begin
                array_free <= 1'b0;
                if (last_pix) begin
                    p_cnt <= '0;
                    k_cnt <= k_cnt + CNT_W'(1);
                end else begin
                    p_cnt <= p_cnt + CNT_W'(1);
                end
            end
            if (beat_take) begin
                beat_cnt <= beat_cnt + 2'd1;
                res_we   <= 1'b1;
                res_data <= i_arr_data;
                res_addr <= res_base + RES_AW'({t_cnt, 2'b00}) + RES_AW'(beat_cnt);
                // In DRAIN the outstanding tile is necessarily the job's last one.
                res_last <= fourth_beat && (state == S_DRAIN);
                if (fourth_beat) begin
                    array_free <= 1'b1;
                    t_cnt      <= t_cnt + RES_AW'(1);
                end
            end else begin
                res_we   <= 1'b0;
                res_last <= 1'b0;
            end
        end
    end

    assign o_busy           = (state == S_FETCH) || (state == S_WAIT) ||
                              (state == S_LAUNCH) || (state == S_DRAIN);
    assign o_done           = (state == S_DONE);
    assign o_img_rd_en      = (state == S_FETCH) && !f_cnt[2];
    assign o_w_rd_en        = o_img_rd_en;
    assign o_img_rd_addr    = img_base + IMG_AW'({p_cnt, 2'b00}) + IMG_AW'(f_cnt);
    assign o_w_rd_addr      = w_base + W_AW'({k_cnt, 2'b00}) + W_AW'(f_cnt);
    assign o_arr_rst        = ~rst;
    assign o_arr_data_in_en = (state == S_LAUNCH);
    assign o_arr_img        = {img_stage[0], img_stage[1], img_stage[2], img_stage[3]};
    assign o_arr_w          = {w_stage[0], w_stage[1], w_stage[2], w_stage[3]};
    assign o_res_we         = res_we;
    assign o_res_addr       = res_addr;
    assign o_res_data       = res_data;

endmodule

// File: tb/tb_conv_pe_tile_scheduler.sv
// tb/tb_conv_pe_tile_scheduler.sv - scoreboard bench for conv_pe_tile_scheduler
module tb_conv_pe_tile_scheduler;
    localparam int IMG_AW = 10;
    localparam int W_AW   = 10;
    localparam int RES_AW = 12;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, i_start;
    logic [CNT_W-1:0]  i_num_pix_grp, i_num_ker_grp;
    logic [IMG_AW-1:0] i_img_base;
    logic [W_AW-1:0]   i_w_base;
    logic [RES_AW-1:0] i_res_base;
    logic              o_busy, o_done, o_img_rd_en, o_w_rd_en;
    logic [IMG_AW-1:0] o_img_rd_addr;
    logic [W_AW-1:0]   o_w_rd_addr;
    logic [143:0]      i_img_rd_data, i_w_rd_data;
    logic              o_arr_rst, o_arr_data_in_en;
    logic [575:0]      o_arr_img, o_arr_w;
    logic [63:0]       i_arr_data;
    logic              i_arr_data_en;
    logic              o_res_we;
    logic [RES_AW-1:0] o_res_addr;
    logic [63:0]       o_res_data;

    logic        model_en = 1'b0, spur_en = 1'b0;
    logic [63:0] model_data = '0, spur_data = '0;
    assign i_arr_data_en = model_en | spur_en;
    assign i_arr_data    = model_en ? model_data : spur_data;

    conv_pe_tile_scheduler #(.IMG_AW(IMG_AW), .W_AW(W_AW), .RES_AW(RES_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_num_pix_grp(i_num_pix_grp), .i_num_ker_grp(i_num_ker_grp),
        .i_img_base(i_img_base), .i_w_base(i_w_base), .i_res_base(i_res_base),
        .o_busy(o_busy), .o_done(o_done),
        .o_img_rd_en(o_img_rd_en), .o_img_rd_addr(o_img_rd_addr), .i_img_rd_data(i_img_rd_data),
        .o_w_rd_en(o_w_rd_en), .o_w_rd_addr(o_w_rd_addr), .i_w_rd_data(i_w_rd_data),
        .o_arr_rst(o_arr_rst), .o_arr_data_in_en(o_arr_data_in_en),
        .o_arr_img(o_arr_img), .o_arr_w(o_arr_w),
        .i_arr_data(i_arr_data), .i_arr_data_en(i_arr_data_en),
        .o_res_we(o_res_we), .o_res_addr(o_res_addr), .o_res_data(o_res_data)
    );

    typedef struct {
        int           cyc;
        logic [575:0] img;
        logic [575:0] w;
    } launch_t;
    typedef struct {
        int                cyc;
        logic [RES_AW-1:0] addr;
        logic [63:0]       data;
    } wr_t;

    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;
    int      exp_img_addr[$];
    int      exp_w_addr[$];
    launch_t exp_launch[$];
    wr_t     exp_wr[$];
    int      exp_done[$];
    launch_t arr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [143:0] img_word(input logic [IMG_AW-1:0] a);
        return {8{2'b10, a, 6'h15}};
    endfunction

    function automatic logic [143:0] w_word(input logic [W_AW-1:0] a);
        return {8{a, 8'hC3}};
    endfunction

    function automatic logic [63:0] beat_val(input logic [575:0] img, input logic [575:0] w, input int r);
        return {img[31:0], w[31:0]} ^ 64'(r);
    endfunction

    task automatic chk(input string name, input logic [575:0] got, input logic [575:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Buffer models: registered read data, one cycle after the strobe.
    always @(posedge clk) begin
        if (o_img_rd_en) i_img_rd_data <= img_word(o_img_rd_addr);
        if (o_w_rd_en)   i_w_rd_data   <= w_word(o_w_rd_addr);
    end

    // Monitor plus array model: beats at launch+13..launch+16.
    always @(negedge clk) begin : mon
        launch_t el;
        wr_t     ew;
        int      d;
        if (rst) begin
            if (o_img_rd_en) begin
                if (exp_img_addr.size() == 0) chk("unexpected_read", 576'(o_img_rd_en), 576'(0));
                else begin
                    chk("img_addr", 576'(o_img_rd_addr), 576'(exp_img_addr.pop_front()));
                    chk("w_addr", 576'(o_w_rd_addr), 576'(exp_w_addr.pop_front()));
                end
                chk("w_rd_en", 576'(o_w_rd_en), 576'(1));
            end
            if (o_arr_data_in_en) begin
                if (exp_launch.size() == 0) chk("unexpected_launch", 576'(o_arr_data_in_en), 576'(0));
                else begin
                    el = exp_launch.pop_front();
                    chk("launch_cyc", 576'(cyc), 576'(el.cyc));
                    chk("launch_img", o_arr_img, el.img);
                    chk("launch_w", o_arr_w, el.w);
                end
                el.cyc = cyc; el.img = o_arr_img; el.w = o_arr_w;
                arr_q.push_back(el);
            end
            if (o_res_we) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 576'(o_res_we), 576'(0));
                else begin
                    ew = exp_wr.pop_front();
                    chk("wr_cyc", 576'(cyc), 576'(ew.cyc));
                    chk("wr_addr", 576'(o_res_addr), 576'(ew.addr));
                    chk("wr_data", 576'(o_res_data), 576'(ew.data));
                end
            end
            if (o_done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 576'(o_done), 576'(0));
                else chk("done_cyc", 576'(cyc), 576'(exp_done.pop_front()));
                chk("done_busy", 576'(o_busy), 576'(0));
            end
            model_en = 1'b0;
            if (arr_q.size() > 0) begin
                d = cyc - arr_q[0].cyc;
                if (d >= 13 && d <= 16) begin
                    model_en   = 1'b1;
                    model_data = beat_val(arr_q[0].img, arr_q[0].w, d - 13);
                    if (d == 16) void'(arr_q.pop_front());
                end
            end
        end else begin
            arr_q.delete();
            model_en = 1'b0;
        end
    end

    task automatic push_job(input int s, input int np, input int nk, input int ib, input int wb, input int rb);
        launch_t el;
        wr_t     ew;
        int      n, p, k;
        n = np * nk;
        if (n == 0) begin
            exp_done.push_back(s + 1);
            return;
        end
        for (int t = 0; t < n; t++) begin
            p = t % np;
            k = t / np;
            for (int f = 0; f < 4; f++) begin
                exp_img_addr.push_back((ib + 4*p + f) & 1023);
                exp_w_addr.push_back((wb + 4*k + f) & 1023);
                el.img[575-144*f -: 144] = img_word(IMG_AW'(ib + 4*p + f));
                el.w[575-144*f -: 144]   = w_word(W_AW'(wb + 4*k + f));
            end
            el.cyc = s + 6 + 17*t;
            exp_launch.push_back(el);
            for (int r = 0; r < 4; r++) begin
                ew.cyc  = s + 20 + 17*t + r;
                ew.addr = RES_AW'(rb + 4*t + r);
                ew.data = beat_val(el.img, el.w, r);
                exp_wr.push_back(ew);
            end
        end
        exp_done.push_back(s + 24 + 17*(n-1));
    endtask

    task automatic drive_start(input int np, input int nk, input int ib, input int wb, input int rb, output int s);
        @(negedge clk);
        i_num_pix_grp = CNT_W'(np);
        i_num_ker_grp = CNT_W'(nk);
        i_img_base    = IMG_AW'(ib);
        i_w_base      = W_AW'(wb);
        i_res_base    = RES_AW'(rb);
        i_start       = 1'b1;
        s             = cyc;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic run_job(input int np, input int nk, input int ib, input int wb, input int rb);
        int s;
        drive_start(np, nk, ib, wb, rb, s);
        push_job(s, np, nk, ib, wb, rb);
    endtask

    task automatic wait_quiet(input int budget);
        int i = 0;
        while ((exp_done.size() > 0 || exp_wr.size() > 0 || exp_launch.size() > 0 ||
                exp_img_addr.size() > 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        repeat (4) @(negedge clk);
        chk("pending_reads", 576'(exp_img_addr.size()), 576'(0));
        chk("pending_launches", 576'(exp_launch.size()), 576'(0));
        chk("pending_writes", 576'(exp_wr.size()), 576'(0));
        chk("pending_done", 576'(exp_done.size()), 576'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 576'(o_busy), 576'(0));
        chk({tag, "_done"}, 576'(o_done), 576'(0));
        chk({tag, "_img_rd_en"}, 576'(o_img_rd_en), 576'(0));
        chk({tag, "_w_rd_en"}, 576'(o_w_rd_en), 576'(0));
        chk({tag, "_launch"}, 576'(o_arr_data_in_en), 576'(0));
        chk({tag, "_res_we"}, 576'(o_res_we), 576'(0));
        chk({tag, "_arr_rst"}, 576'(o_arr_rst), 576'(1));
        chk({tag, "_arr_img"}, o_arr_img, 576'(0));
        chk({tag, "_arr_w"}, o_arr_w, 576'(0));
        chk({tag, "_res_addr"}, 576'(o_res_addr), 576'(0));
        chk({tag, "_img_addr"}, 576'(o_img_rd_addr), 576'(0));
    endtask

    initial begin
        int s;
        rst = 1'b0; i_start = 1'b0;
        i_num_pix_grp = '0; i_num_ker_grp = '0;
        i_img_base = '0; i_w_base = '0; i_res_base = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_job(1, 1, 0, 0, 0);
        wait_quiet(200);

        run_job(2, 2, 8, 16, 100);
        wait_quiet(300);

        run_job(0, 3, 5, 5, 5);
        wait_quiet(20);

        run_job(2, 2, 8, 16, 100);
        repeat (8) @(negedge clk);
        i_num_pix_grp = 8'd1; i_num_ker_grp = 8'd1;
        i_img_base = 10'd500; i_w_base = 10'd600; i_res_base = 12'd900;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_quiet(300);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            spur_en   = 1'b1;
            spur_data = {$urandom, $urandom};
        end
        @(negedge clk);
        spur_en = 1'b0;
        repeat (3) @(negedge clk);
        run_job(1, 1, 0, 0, 0);
        wait_quiet(200);

        drive_start(2, 1, 0, 0, 0, s);
        for (int f = 0; f < 4; f++) begin
            exp_img_addr.push_back(f);
            exp_w_addr.push_back(f);
        end
        for (int f = 0; f < 4; f++) begin
            exp_img_addr.push_back(4 + f);
            exp_w_addr.push_back(f);
        end
        begin
            launch_t el;
            for (int f = 0; f < 4; f++) begin
                el.img[575-144*f -: 144] = img_word(IMG_AW'(f));
                el.w[575-144*f -: 144]   = w_word(W_AW'(f));
            end
            el.cyc = s + 6;
            exp_launch.push_back(el);
        end
        while (cyc < s + 15) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_wait");
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_reads", 576'(exp_img_addr.size()), 576'(0));
        run_job(1, 1, 0, 0, 0);
        wait_quiet(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_pe_tile_scheduler.md
Name: conv_pe_tile_scheduler

Overview:
Sequences the 4x4 systolic convolution PE array over a job of (pixel-group x kernel-group) tiles.
- Per tile: fetches four 144-bit image vectors and four 144-bit weight vectors from on-chip buffers into a staging register, then fires a one-cycle launch to the array.
- Collects the four 64-bit result beats and writes them to the result buffer.
- Sits between the layer controller (start/done) and the PE array plus its image, weight and result buffers.

Parameters:
IMG_AW, 10, image buffer address width
W_AW, 10, weight buffer address width
RES_AW, 12, result buffer address width
CNT_W, 8, width of tile-count fields

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
i_start  in  1  job start pulse; ignored while o_busy=1
i_num_pix_grp  in  CNT_W  pixel groups (P); 4 pixels per group
i_num_ker_grp  in  CNT_W  kernel groups (K); 4 kernels per group
i_img_base  in  IMG_AW  image buffer base address
i_w_base  in  W_AW  weight buffer base address
i_res_base  in  RES_AW  result buffer base address
o_busy  out  1  job in progress
o_done  out  1  one-cycle pulse at job end
o_img_rd_en  out  1  image buffer read strobe
o_img_rd_addr  out  IMG_AW  image read address
i_img_rd_data  in  144  image read data; valid the cycle after the strobe
o_w_rd_en  out  1  weight buffer read strobe
o_w_rd_addr  out  W_AW  weight read address
i_w_rd_data  in  144  weight read data; valid the cycle after the strobe
o_arr_rst  out  1  active-high array reset, equals ~rst (combinational)
o_arr_data_in_en  out  1  array launch pulse
o_arr_img  out  576  staged image lanes; lane n at [575-144n -: 144]
o_arr_w  out  576  staged weight lanes; same packing as o_arr_img
i_arr_data  in  64  array result beat
i_arr_data_en  in  1  array result valid
o_res_we  out  1  result write enable
o_res_addr  out  RES_AW  result write address
o_res_data  out  64  result write data

Behaviour:
- Reset (rst=0): all outputs 0 (o_arr_rst=1), state IDLE, staging cleared, array_free=1, all counters 0. Reset mid-job aborts the job with no o_done.
- Job latch: i_start in IDLE latches P, K and the three base addresses, sets o_busy.
  - If P=0 or K=0: no reads and no launches; next cycle o_done=1 and o_busy=0.
- Tile order: kernel group k outer (0..K-1), pixel group p inner (0..P-1).
- States IDLE -> FETCH -> (WAIT) -> LAUNCH -> FETCH | DRAIN -> IDLE.
- FETCH lasts 5 cycles, f=0..4.
  - For f<=3: o_img_rd_en=o_w_rd_en=1, img addr = img_base + 4p + f, weight addr = w_base + 4k + f.
  - For f>=1: lane f-1 of both staging registers captures the read data.
  - After f=4: go to LAUNCH if array_free, else WAIT.
- WAIT: hold until array_free=1, then go to LAUNCH.
- LAUNCH: 1 cycle.
  - o_arr_data_in_en=1 with staging stable; clear array_free; advance (p,k).
  - Next state FETCH if tiles remain, else DRAIN.
  - Staging may be overwritten from the next cycle, because the array captures on launch.
- Array timing contract: for a launch at cycle T, result beats (rows 0..3) arrive at T+13..T+16; the next launch is legal from T+17.
- array_free is set the cycle after the 4th beat of the outstanding launch.
- Beat handling:
  - A 2-bit beat counter counts i_arr_data_en only while a launch is outstanding; beats with no outstanding launch are ignored.
  - Each beat produces a registered write one cycle later: o_res_we=1, o_res_data = beat, o_res_addr = res_base + 4*t + beat_idx.
  - t is the completed-tile counter, incremented on the 4th beat.
- Address arithmetic truncates (wraps) modulo each address width. CNT_W counters compare with ==; no wrap.
- DRAIN: wait for the last tile's 4th result write; in the cycle after it, o_done=1 and o_busy=0, return to IDLE.
- Single-tile latency: start at S, launch at S+6, writes at S+14..S+17 relative to launch, i.e. S+20..S+23; o_done at S+24.
- Steady-state throughput: one tile per 17 cycles. Fetch overlaps array compute.

Test Plan:
- P=1, K=1, bases 0: start at cycle 0.
  - Reads addr 0..3 on cycles 1..4; launch at cycle 6 with lanes = words 0..3.
  - Writes res addr 0..3 with array beats at cycles 20..23; o_done at 24.
- P=2, K=2, img_base=8, w_base=16, res_base=100.
  - Image fetch addresses 8-11,12-15,8-11,12-15; weight fetch addresses 16-19,16-19,20-23,20-23.
  - Launches 17 cycles apart; result addresses 100..115 in order; one o_done.
- P=0, K=3: start -> o_done the next cycle; no rd_en, launch or we.
- i_start pulsed again mid-job: ignored; outputs identical to the single-start run.
- rst=0 during the WAIT of tile 2: all outputs 0, o_arr_rst=1.
  - After release, a fresh P=1,K=1 job runs with the scenario 1 timing.
- Spurious i_arr_data_en in IDLE: no o_res_we; array_free stays 1.
